// File: rtl/hdmi_align_pkg.sv
// Shared definitions for the TMDS word aligner: control-token patterns and FSM states.
package hdmi_align_pkg;

   localparam logic [9:0] TMDS_TOKEN0 = 10'b1101010100;
   localparam logic [9:0] TMDS_TOKEN1 = 10'b0010101011;
   localparam logic [9:0] TMDS_TOKEN2 = 10'b0101010100;
   localparam logic [9:0] TMDS_TOKEN3 = 10'b1010101011;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_SEARCH,
      ST_LOCKED
   } align_state_t;

endpackage

// File: rtl/word_slip_mux.sv
// Two-word history buffer with a registered, offset-indexed word select.
module word_slip_mux #(
   parameter int WIDTH = 10,
   parameter int OW    = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic [WIDTH-1:0] data_in,
   input  logic [OW-1:0]    offset,
   output logic [WIDTH-1:0] data_out
);

   logic [2*WIDTH-1:0] buff;
   logic [WIDTH-1:0]   sel;

   // Offset k takes the window ending k bits below the newest word's MSB.
   always_comb begin
      sel = buff[2*WIDTH-1 -: WIDTH];
      for (int i = 1; i < WIDTH; i++) begin
         if (offset == OW'(i)) sel = buff[2*WIDTH-1-i -: WIDTH];
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         buff     <= '0;
         data_out <= '0;
      end else begin
         buff     <= {data_in, buff[2*WIDTH-1:WIDTH]};
         data_out <= sel;
      end
   end

endmodule

// File: rtl/tmds_word_aligner.sv
// Per-channel TMDS word aligner: manual bitslip plus an automatic token-hunting lock FSM.
//
// state     | meaning
// ST_IDLE   | manual mode or just out of reset, counters clear
// ST_SETTLE | two cycles for a new offset to reach data_out
// ST_SEARCH | counting token hits over one window at the current offset
// ST_LOCKED | aligned; counting token-free windows toward loss of lock
module tmds_word_aligner
   import hdmi_align_pkg::*;
#(
   parameter int              WIDTH         = 10,
   parameter int              SEARCH_WINDOW = 4096,
   parameter int              LOCK_COUNT    = 8,
   parameter int              MISS_LIMIT    = 4,
   parameter logic [WIDTH-1:0] TOKEN0       = WIDTH'(TMDS_TOKEN0),
   parameter logic [WIDTH-1:0] TOKEN1       = WIDTH'(TMDS_TOKEN1),
   parameter logic [WIDTH-1:0] TOKEN2       = WIDTH'(TMDS_TOKEN2),
   parameter logic [WIDTH-1:0] TOKEN3       = WIDTH'(TMDS_TOKEN3),
   localparam int             OW            = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic [WIDTH-1:0] data_in,
   input  logic             bitslip,
   input  logic             auto_en,
   output logic [WIDTH-1:0] data_out,
   output logic [OW-1:0]    offset,
   output logic             locked,
   output logic             sweep_fail
);

   localparam int WW = (SEARCH_WINDOW > 1) ? $clog2(SEARCH_WINDOW) : 1;
   localparam int HW = $clog2(LOCK_COUNT + 1);
   localparam int MW = $clog2(MISS_LIMIT + 1);

   align_state_t  state, state_nxt;
   logic [WW-1:0] win_cnt, win_nxt;
   logic [HW-1:0] hit_cnt, hit_nxt, hit_upd;
   logic [MW-1:0] miss_cnt, miss_nxt;
   logic          settle_cnt, settle_nxt;
   logic          dly1, dly2, auto_q1, auto_q2;
   logic          match, win_end, auto_slip, man_slip, sweep_nxt;

   word_slip_mux #(.WIDTH(WIDTH), .OW(OW)) u_mux (
      .clk      (clk),
      .rstn     (rstn),
      .data_in  (data_in),
      .offset   (offset),
      .data_out (data_out)
   );

   assign match   = (data_out == TOKEN0) || (data_out == TOKEN1) ||
                    (data_out == TOKEN2) || (data_out == TOKEN3);
   assign win_end = (win_cnt == WW'(SEARCH_WINDOW - 1));
   assign hit_upd = (match && (hit_cnt != HW'(LOCK_COUNT))) ? hit_cnt + 1'b1 : hit_cnt;
   assign locked  = (state == ST_LOCKED);

   // A manual request whose trip through the delay line overlapped auto mode is dropped.
   assign man_slip = dly1 & ~dly2 & ~auto_en & ~auto_q1 & ~auto_q2;

   always_comb begin
      state_nxt  = state;
      win_nxt    = win_cnt;
      hit_nxt    = hit_cnt;
      miss_nxt   = miss_cnt;
      settle_nxt = 1'b0;
      auto_slip  = 1'b0;
      sweep_nxt  = 1'b0;
      if (!auto_en) begin
         state_nxt = ST_IDLE;
         win_nxt   = '0;
         hit_nxt   = '0;
         miss_nxt  = '0;
      end else begin
         case (state)
            ST_IDLE: begin
               state_nxt = ST_SETTLE;
               win_nxt   = '0;
               hit_nxt   = '0;
               miss_nxt  = '0;
            end
            ST_SETTLE: begin
               win_nxt    = '0;
               hit_nxt    = '0;
               miss_nxt   = '0;
               settle_nxt = ~settle_cnt;
               if (settle_cnt) state_nxt = ST_SEARCH;
            end
            ST_SEARCH: begin
               win_nxt = win_cnt + 1'b1;
               hit_nxt = hit_upd;
               if (win_end) begin
                  win_nxt = '0;
                  hit_nxt = '0;
                  if (hit_upd >= HW'(LOCK_COUNT)) begin
                     state_nxt = ST_LOCKED;
                  end else begin
                     auto_slip = 1'b1;
                     sweep_nxt = (offset == OW'(WIDTH - 1));
                     state_nxt = ST_SETTLE;
                  end
               end
            end
            ST_LOCKED: begin
               win_nxt = win_cnt + 1'b1;
               hit_nxt = hit_upd;
               if (win_end) begin
                  win_nxt = '0;
                  hit_nxt = '0;
                  if (hit_upd != '0) begin
                     miss_nxt = '0;
                  end else if (miss_cnt == MW'(MISS_LIMIT - 1)) begin
                     miss_nxt  = '0;
                     auto_slip = 1'b1;
                     state_nxt = ST_SETTLE;
                  end else begin
                     miss_nxt = miss_cnt + 1'b1;
                  end
               end
            end
            default: state_nxt = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state      <= ST_IDLE;
         win_cnt    <= '0;
         hit_cnt    <= '0;
         miss_cnt   <= '0;
         settle_cnt <= 1'b0;
         dly1       <= 1'b0;
         dly2       <= 1'b0;
         auto_q1    <= 1'b0;
         auto_q2    <= 1'b0;
         offset     <= '0;
         sweep_fail <= 1'b0;
      end else begin
         state      <= state_nxt;
         win_cnt    <= win_nxt;
         hit_cnt    <= hit_nxt;
         miss_cnt   <= miss_nxt;
         settle_cnt <= settle_nxt;
         dly1       <= bitslip;
         dly2       <= dly1;
         auto_q1    <= auto_en;
         auto_q2    <= auto_q1;
         sweep_fail <= sweep_nxt;
         if (auto_slip || man_slip)
            offset <= (offset == OW'(WIDTH - 1)) ? '0 : offset + 1'b1;
      end
   end

endmodule

// File: tb/tb_tmds_word_aligner.sv
// Directed bench for tmds_word_aligner: reset, manual slip, auto lock/unlock, sweep and mode change.
module tb_tmds_word_aligner;

   localparam logic [9:0] T0   = 10'b1101010100;
   localparam logic [9:0] ROT3 = 10'b1001101010;
   localparam logic [9:0] FLAT = 10'b0000011111;

   logic       clk = 1'b0;
   logic       rstn;
   logic [9:0] data_in;
   logic       bitslip;
   logic       auto_en;
   logic [9:0] data_out;
   logic [3:0] offset;
   logic       locked;
   logic       sweep_fail;

   int n_tests = 0;
   int n_fail  = 0;

   tmds_word_aligner #(
      .WIDTH(10), .SEARCH_WINDOW(16), .LOCK_COUNT(4), .MISS_LIMIT(2)
   ) dut (
      .clk        (clk),
      .rstn       (rstn),
      .data_in    (data_in),
      .bitslip    (bitslip),
      .auto_en    (auto_en),
      .data_out   (data_out),
      .offset     (offset),
      .locked     (locked),
      .sweep_fail (sweep_fail)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   function automatic logic [9:0] rotl(input logic [9:0] v, input int k);
      return (v << k) | (v >> (10 - k));
   endfunction

   function automatic logic [9:0] rand_word();
      logic [9:0] w;
      do w = 10'($urandom);
      while (w == 10'b1101010100 || w == 10'b0010101011 ||
             w == 10'b0101010100 || w == 10'b1010101011);
      return w;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      bit sweep_seen;
      bit lock_seen;
      int t_pulse[$];

      // reset
      rstn = 1'b0; auto_en = 1'b0; bitslip = 1'b0; data_in = rand_word();
      repeat (3) @(negedge clk) data_in = rand_word();
      check("rst_data", data_out, 0);
      check("rst_offset", offset, 0);
      check("rst_locked", locked, 0);
      check("rst_sweep", sweep_fail, 0);
      @(negedge clk); rstn = 1'b1; data_in = 10'h2b5;
      @(posedge clk); #1;
      check("rst_lat1", data_out, 0);
      @(negedge clk); data_in = T0;
      @(posedge clk); #1;
      check("rst_first", data_out, 10'h2b5);
      repeat (3) @(posedge clk);

      // manual slip
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk); bitslip = 1'b1;
         @(posedge clk); #1;
         check($sformatf("man_pre%0d", k), offset, (k - 1) % 10);
         @(negedge clk); bitslip = 1'b0;
         @(posedge clk); #1;
         check($sformatf("man_off%0d", k), offset, k % 10);
         check($sformatf("man_old%0d", k), data_out, rotl(T0, k - 1));
         @(posedge clk); #1;
         check($sformatf("man_dat%0d", k), data_out, rotl(T0, k % 10));
         repeat (2) @(posedge clk);
      end

      // auto lock on TOKEN0 rotated right by 3
      @(negedge clk); auto_en = 1'b1; data_in = ROT3;
      n = 0; sweep_seen = 1'b0;
      for (int i = 1; i <= 80; i++) begin
         @(posedge clk); #1;
         if (sweep_fail) sweep_seen = 1'b1;
         if (locked) begin n = i; break; end
      end
      check("lock_cycles", n, 73);
      check("lock_offset", offset, 3);
      check("lock_data", data_out, T0);
      check("lock_nosweep", sweep_seen, 0);

      // loss of lock
      data_in = FLAT;
      n = 0;
      for (int i = 1; i <= 70; i++) begin
         @(posedge clk); #1;
         if (!locked) begin n = i; break; end
      end
      check("unlock_cycles", n, 48);
      check("unlock_offset", offset, 4);

      // no tokens: sweep_fail period
      lock_seen = 1'b0;
      for (int i = 0; i < 700 && t_pulse.size() < 3; i++) begin
         @(negedge clk); data_in = rand_word();
         @(posedge clk); #1;
         if (locked) lock_seen = 1'b1;
         if (sweep_fail) t_pulse.push_back(i);
      end
      check("nt_pulses", t_pulse.size(), 3);
      check("nt_nolock", lock_seen, 0);
      if (t_pulse.size() == 3) begin
         check("nt_period1", t_pulse[1] - t_pulse[0], 180);
         check("nt_period2", t_pulse[2] - t_pulse[1], 180);
      end
      check("nt_wrap_off", offset, 0);

      // mode change mid-SEARCH with a simultaneous bitslip
      repeat (6) @(negedge clk) data_in = rand_word();
      auto_en = 1'b0; bitslip = 1'b1;
      @(posedge clk); #1;
      check("mc_hold0", offset, 0);
      check("mc_locked", locked, 0);
      @(negedge clk); bitslip = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      check("mc_noslip", offset, 0);
      @(negedge clk); bitslip = 1'b1;
      @(negedge clk); bitslip = 1'b0;
      @(posedge clk); #1;
      check("mc_manual", offset, 1);

      // relock at offset 1, then drop auto_en while locked
      @(negedge clk); data_in = rotl(T0, 9);
      repeat (3) @(negedge clk);
      auto_en = 1'b1;
      n = 0;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk); #1;
         if (locked) begin n = i; break; end
      end
      check("relock_cycles", n, 19);
      check("relock_data", data_out, T0);
      @(negedge clk); auto_en = 1'b0;
      @(posedge clk); #1;
      check("drop_locked", locked, 0);
      check("drop_offset", offset, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
